// File: rtl/k12_alu_pkg.sv
// Shared constants and state type for the k12 sequential ALU.
// Operation codes, condition-select codes and the controller state enum.
package k12_alu_pkg;

  localparam logic [3:0] FN_PASS_A = 4'd0;
  localparam logic [3:0] FN_AND    = 4'd1;
  localparam logic [3:0] FN_OR     = 4'd2;
  localparam logic [3:0] FN_XOR    = 4'd3;
  localparam logic [3:0] FN_ADD    = 4'd4;
  localparam logic [3:0] FN_SUB    = 4'd5;
  localparam logic [3:0] FN_ASR    = 4'd6;
  localparam logic [3:0] FN_PASS_B = 4'd7;
  localparam logic [3:0] FN_SLL    = 4'd8;
  localparam logic [3:0] FN_SRL    = 4'd9;
  localparam logic [3:0] FN_MUL    = 4'd10;
  localparam logic [3:0] FN_CMP    = 4'd11;

  localparam logic [2:0] CC_ZERO   = 3'd0;
  localparam logic [2:0] CC_NEG    = 3'd1;
  localparam logic [2:0] CC_BORROW = 3'd2;
  localparam logic [2:0] CC_OVF    = 3'd3;
  localparam logic [2:0] CC_NZERO  = 3'd4;
  localparam logic [2:0] CC_LEU    = 3'd5;
  localparam logic [2:0] CC_LT     = 3'd6;
  localparam logic [2:0] CC_LE     = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_MUL   = 2'd2,
    ST_HOLD  = 2'd3
  } state_e;

endpackage

// File: rtl/k12_alu_seq_if.sv
// Request/result bus of the k12 sequential ALU.
// master = requester/consumer side, slave = the ALU.
interface k12_alu_seq_if #(parameter int WIDTH = 8);

  logic             in_valid;
  logic             in_ready;
  logic [3:0]       func;
  logic             use_imm;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] imm;
  logic [2:0]       cc;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] res;
  logic             cond;

  modport master (
    output in_valid, func, use_imm, a, b, imm, cc, out_ready,
    input  in_ready, out_valid, res, cond
  );

  modport slave (
    input  in_valid, func, use_imm, a, b, imm, cc, out_ready,
    output in_ready, out_valid, res, cond
  );

endinterface

// File: rtl/k12_alu_flags.sv
// Combinational compare flags (a - bi) and condition selection.
// Flags always describe a - bi, whatever operation is being issued.
module k12_alu_flags
  import k12_alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] bi,
  input  logic [2:0]       cc,
  output logic             cond
);

  logic [WIDTH:0] diff_s;
  logic           zero_s;
  logic           neg_s;
  logic           borrow_s;
  logic           ovf_s;

  // Subtract via a + ~bi + 1 and derive the four flags
  always_comb begin
    diff_s   = {1'b0, a} + {1'b0, ~bi} + {{WIDTH{1'b0}}, 1'b1};
    zero_s   = (diff_s[WIDTH-1:0] == {WIDTH{1'b0}});
    neg_s    = diff_s[WIDTH-1];
    borrow_s = ~diff_s[WIDTH];
    ovf_s    = (a[WIDTH-1] ^ bi[WIDTH-1]) & (diff_s[WIDTH-1] ^ a[WIDTH-1]);
  end

  // Condition multiplexer
  always_comb begin
    cond = 1'b0;
    case (cc)
      CC_ZERO:   cond = zero_s;
      CC_NEG:    cond = neg_s;
      CC_BORROW: cond = borrow_s;
      CC_OVF:    cond = ovf_s;
      CC_NZERO:  cond = ~zero_s;
      CC_LEU:    cond = borrow_s | zero_s;
      CC_LT:     cond = neg_s ^ ovf_s;
      CC_LE:     cond = (neg_s ^ ovf_s) | zero_s;
      default:   cond = 1'b0;
    endcase
  end

endmodule

// File: rtl/k12_alu_seq.sv
// Sequential ALU: single-cycle ops, bit-serial shifts, optional shift-add multiply.
// Define K12_ALU_SEQ_MUL_EN to build the multiplier; otherwise func 10 is reserved.
module k12_alu_seq
  import k12_alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  k12_alu_seq_if.slave  bus
);

  localparam int SAW = $clog2(WIDTH);
  localparam int CW  = $clog2(WIDTH + 1);

  state_e           state_r, state_s, ld_state_s;
  logic [WIDTH-1:0] res_r, res_s, ld_res_s;
  logic             cond_r, cond_s;
  logic             out_valid_r, out_valid_s;
  logic [CW-1:0]    cnt_r, cnt_s, ld_cnt_s;
  logic             dir_r, dir_s, ld_dir_s;
  logic [WIDTH-1:0] bi_s;
  logic [SAW-1:0]   amt_s;
  logic             flag_cond_s;
  logic             accept_s;
`ifdef K12_ALU_SEQ_MUL_EN
  logic [WIDTH-1:0] mcand_r, mcand_s;
  logic [WIDTH-1:0] mplier_r, mplier_s;
`endif

  assign bi_s         = bus.use_imm ? bus.imm : bus.b;
  assign amt_s        = bi_s[SAW-1:0];
  assign bus.in_ready = (state_r == ST_IDLE) || ((state_r == ST_HOLD) && bus.out_ready);
  assign accept_s     = bus.in_valid && bus.in_ready;
  assign bus.out_valid = out_valid_r;
  assign bus.res      = res_r;
  assign bus.cond     = cond_r;

  k12_alu_flags #(.WIDTH(WIDTH)) u_flags (
    .a    (bus.a),
    .bi   (bi_s),
    .cc   (bus.cc),
    .cond (flag_cond_s)
  );

  // Decode an incoming request into its first state and initial result
  always_comb begin
    ld_state_s = ST_HOLD;
    ld_res_s   = {WIDTH{1'b0}};
    ld_cnt_s   = {CW{1'b0}};
    ld_dir_s   = 1'b0;
    case (bus.func)
      FN_PASS_A: ld_res_s = bus.a;
      FN_AND:    ld_res_s = bus.a & bi_s;
      FN_OR:     ld_res_s = bus.a | bi_s;
      FN_XOR:    ld_res_s = bus.a ^ bi_s;
      FN_ADD:    ld_res_s = bus.a + bi_s;
      FN_SUB:    ld_res_s = bus.a - bi_s;
      FN_ASR:    ld_res_s = {bus.a[WIDTH-1], bus.a[WIDTH-1:1]};
      FN_PASS_B: ld_res_s = bi_s;
      FN_SLL, FN_SRL: begin
        ld_res_s = bus.a;
        ld_dir_s = (bus.func == FN_SRL);
        if (amt_s != {SAW{1'b0}}) begin
          ld_state_s = ST_SHIFT;
          ld_cnt_s   = CW'(amt_s);
        end else begin
          ld_state_s = ST_HOLD;
        end
      end
`ifdef K12_ALU_SEQ_MUL_EN
      FN_MUL: begin
        ld_state_s = ST_MUL;
        ld_cnt_s   = CW'(WIDTH);
      end
`else
      FN_MUL:    ld_res_s = {WIDTH{1'b0}};
`endif
      FN_CMP:    ld_res_s = bus.a;
      default:   ld_res_s = {WIDTH{1'b0}};
    endcase
  end

  // Next-state and datapath update; an accept overrides the current state
  always_comb begin
    state_s = state_r;
    res_s   = res_r;
    cond_s  = cond_r;
    cnt_s   = cnt_r;
    dir_s   = dir_r;
`ifdef K12_ALU_SEQ_MUL_EN
    mcand_s  = mcand_r;
    mplier_s = mplier_r;
`endif
    if (accept_s) begin
      state_s = ld_state_s;
      res_s   = ld_res_s;
      cond_s  = flag_cond_s;
      cnt_s   = ld_cnt_s;
      dir_s   = ld_dir_s;
`ifdef K12_ALU_SEQ_MUL_EN
      mcand_s  = bus.a;
      mplier_s = bi_s;
`endif
    end else begin
      case (state_r)
        ST_IDLE: state_s = ST_IDLE;
        ST_HOLD: begin
          if (bus.out_ready) begin
            state_s = ST_IDLE;
          end else begin
            state_s = ST_HOLD;
          end
        end
        ST_SHIFT: begin
          res_s = dir_r ? {1'b0, res_r[WIDTH-1:1]} : {res_r[WIDTH-2:0], 1'b0};
          cnt_s = cnt_r - CW'(1);
          if (cnt_r == CW'(1)) begin
            state_s = ST_HOLD;
          end else begin
            state_s = ST_SHIFT;
          end
        end
`ifdef K12_ALU_SEQ_MUL_EN
        ST_MUL: begin
          if (mplier_r[0]) begin
            res_s = res_r + mcand_r;
          end else begin
            res_s = res_r;
          end
          mcand_s  = {mcand_r[WIDTH-2:0], 1'b0};
          mplier_s = {1'b0, mplier_r[WIDTH-1:1]};
          cnt_s    = cnt_r - CW'(1);
          if (cnt_r == CW'(1)) begin
            state_s = ST_HOLD;
          end else begin
            state_s = ST_MUL;
          end
        end
`endif
        default: state_s = ST_IDLE;
      endcase
    end
    out_valid_s = (state_s == ST_HOLD);
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      res_r       <= {WIDTH{1'b0}};
      cond_r      <= 1'b0;
      out_valid_r <= 1'b0;
      cnt_r       <= {CW{1'b0}};
      dir_r       <= 1'b0;
`ifdef K12_ALU_SEQ_MUL_EN
      mcand_r     <= {WIDTH{1'b0}};
      mplier_r    <= {WIDTH{1'b0}};
`endif
    end else begin
      state_r     <= state_s;
      res_r       <= res_s;
      cond_r      <= cond_s;
      out_valid_r <= out_valid_s;
      cnt_r       <= cnt_s;
      dir_r       <= dir_s;
`ifdef K12_ALU_SEQ_MUL_EN
      mcand_r     <= mcand_s;
      mplier_r    <= mplier_s;
`endif
    end
  end

endmodule

// File: tb/tb_k12_alu_seq.sv
// Self-checking bench for k12_alu_seq (WIDTH=8): directed cases, random ops
// against an arithmetic reference model, HOLD back-pressure and mid-op reset.
module tb_k12_alu_seq;

  localparam int W   = 8;
  localparam int MOD = 1 << W;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  k12_alu_seq_if #(.WIDTH(W)) bus ();

  k12_alu_seq #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check_val(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: result, condition and cycles from accept to out_valid
  function automatic void model(input int fn, input int a, input int bi, input int cc,
                                output int res, output int cond, output int lat);
    int amt, sa, sb, sd;
    bit z, n, bw, v;
    lat = 1;
    amt = bi % (1 << $clog2(W));
    case (fn)
      0:  res = a;
      1:  res = a & bi;
      2:  res = a | bi;
      3:  res = a ^ bi;
      4:  res = (a + bi) % MOD;
      5:  res = (a - bi + MOD) % MOD;
      6:  res = (a / 2) + ((a >= MOD / 2) ? MOD / 2 : 0);
      7:  res = bi;
      8:  begin res = (a << amt) % MOD; lat = (amt == 0) ? 1 : amt + 1; end
      9:  begin res = a >> amt; lat = (amt == 0) ? 1 : amt + 1; end
`ifdef K12_ALU_SEQ_MUL_EN
      10: begin res = (a * bi) % MOD; lat = W + 1; end
`else
      10: res = 0;
`endif
      11: res = a;
      default: res = 0;
    endcase
    sa = (a >= MOD / 2) ? a - MOD : a;
    sb = (bi >= MOD / 2) ? bi - MOD : bi;
    sd = sa - sb;
    z  = (a == bi);
    bw = (a < bi);
    n  = ((a - bi + MOD) % MOD) >= MOD / 2;
    v  = (sd < -(MOD / 2)) || (sd > MOD / 2 - 1);
    case (cc)
      0: cond = int'(z);
      1: cond = int'(n);
      2: cond = int'(bw);
      3: cond = int'(v);
      4: cond = int'(!z);
      5: cond = int'(bw | z);
      6: cond = int'(n ^ v);
      default: cond = int'((n ^ v) | z);
    endcase
  endfunction

  task automatic drive_req(input int fn, input int a, input int b, input int imm,
                           input int ui, input int cc);
    bus.func     = 4'(fn);
    bus.a        = W'(a);
    bus.b        = W'(b);
    bus.imm      = W'(imm);
    bus.use_imm  = ui[0];
    bus.cc       = 3'(cc);
    bus.in_valid = 1'b1;
  endtask

  // Issue one op from IDLE, check latency/result, hold it, then release
  task automatic run_op(input string tag, input int fn, input int a, input int b,
                        input int imm, input int ui, input int cc, input int hold);
    int er, ec, el, lat, bi;
    bi = (ui != 0) ? imm : b;
    model(fn, a, bi, cc, er, ec, el);
    check_val({tag, "_idle_rdy"}, int'(bus.in_ready), 1);
    drive_req(fn, a, b, imm, ui, cc);
    bus.out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 64) begin
      check_val({tag, "_busy_rdy"}, int'(bus.in_ready), 0);
      @(negedge clk);
      lat++;
    end
    check_val({tag, "_lat"}, lat, el);
    check_val({tag, "_res"}, int'(bus.res), er);
    check_val({tag, "_cond"}, int'(bus.cond), ec);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check_val({tag, "_hold_vld"}, int'(bus.out_valid), 1);
      check_val({tag, "_hold_res"}, int'(bus.res), er);
      check_val({tag, "_hold_rdy"}, int'(bus.in_ready), 0);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check_val({tag, "_released"}, int'(bus.out_valid), 0);
  endtask

  initial begin
    int er, ec, el, fn;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    drive_req(0, 0, 0, 0, 0, 0);
    bus.in_valid  = 1'b0;

    repeat (3) @(negedge clk);
    check_val("rst_vld", int'(bus.out_valid), 0);
    check_val("rst_res", int'(bus.res), 0);
    check_val("rst_cond", int'(bus.cond), 0);
    rst_n = 1'b1;
    @(negedge clk);
    check_val("post_rst_rdy", int'(bus.in_ready), 1);

    run_op("add_7f", 4, 'h7F, 'h01, 0, 0, 3, 0);
    run_op("sub_bw", 5, 'h05, 'h00, 'h07, 1, 2, 2);
    run_op("sub_lt", 5, 'h05, 'h00, 'h07, 1, 6, 0);
    run_op("shl3", 8, 'h01, 3, 0, 0, 0, 0);
    run_op("shl0", 8, 'h01, 0, 0, 0, 1, 0);
    run_op("srl5", 9, 'hB4, 'h0D, 0, 0, 5, 1);
    run_op("asr", 6, 'h81, 'h00, 0, 0, 7, 0);
    run_op("mul", 10, 12, 13, 0, 0, 4, 0);
    run_op("rsvd", 14, 'h3C, 'h3C, 0, 0, 0, 0);
    run_op("cmp", 11, 'h80, 'h7F, 0, 0, 7, 0);

    // Back-pressure for 5 cycles, then release and accept in the same edge
    run_op("bp_nohold", 3, 'hA5, 'h0F, 0, 0, 4, 0);
    drive_req(4, 'h10, 'h22, 0, 0, 0);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check_val("bp_res", int'(bus.res), 'h32);
      check_val("bp_rdy", int'(bus.in_ready), 0);
      @(negedge clk);
    end
    model(3, 'hF0, 'h3C, 1, er, ec, el);
    bus.out_ready = 1'b1;
    drive_req(3, 'hF0, 'h3C, 0, 0, 1);
    #1;
    check_val("b2b_rdy", int'(bus.in_ready), 1);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    check_val("b2b_vld", int'(bus.out_valid), 1);
    check_val("b2b_res", int'(bus.res), er);
    check_val("b2b_cond", int'(bus.cond), ec);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;

    for (int k = 0; k < 150; k++) begin
      fn = int'($urandom_range(0, 15));
      run_op("rnd", fn, int'($urandom_range(0, MOD - 1)), int'($urandom_range(0, MOD - 1)),
             int'($urandom_range(0, MOD - 1)), int'($urandom_range(0, 1)),
             int'($urandom_range(0, 7)), int'($urandom_range(0, 2)));
    end

    // Reset in the middle of a long operation
`ifdef K12_ALU_SEQ_MUL_EN
    drive_req(10, 12, 13, 0, 0, 2);
`else
    drive_req(8, 'h01, 7, 0, 0, 2);
`endif
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_val("midrst_vld", int'(bus.out_valid), 0);
    check_val("midrst_res", int'(bus.res), 0);
    check_val("midrst_cond", int'(bus.cond), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_val("midrst_rdy", int'(bus.in_ready), 1);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check_val("midrst_novld", int'(bus.out_valid), 0);
    end
    run_op("after_rst", 5, 'h40, 'h41, 0, 0, 6, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
